// File: rtl/seed_word_loader.sv
// seed_word_loader: front-end sequencer for the SEED core.
// Gathers key and text as 32-bit words, drives the core's two-cycle load
// sequence, waits for completion under a watchdog, then streams the
// 128-bit result back out as four 32-bit words.
module seed_word_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [31:0]  i_Word,
  input  logic         i_Mode,
  output logic [128:0] o_Core_Data,
  input  logic [127:0] i_Core_Text,
  input  logic         i_Core_Done,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [31:0]  o_Word,
  output logic         o_Busy,
  output logic         o_Err
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WDW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_COLLECT   = 3'd0,
    S_LOAD_TEXT = 3'd1,
    S_LOAD_KEY  = 3'd2,
    S_WAIT      = 3'd3,
    S_OUT       = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [1:0]          ocnt_q, ocnt_d;
  logic [BLK_W-1:0]    key_q, key_d;
  logic [BLK_W-1:0]    text_q, text_d;
  logic [BLK_W-1:0]    result_q, result_d;
  logic                mode_q, mode_d;
  logic [WDW-1:0]      wdog_q, wdog_d;
  logic [BLK_W:0]      core_data_q, core_data_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                err_q, err_d;
  logic                in_hs_c, out_hs_c;

  // Handshake status and outputs decoded from the current state
  assign o_Ready     = (state_q == S_COLLECT);
  assign o_Valid     = (state_q == S_OUT);
  assign o_Busy      = (state_q != S_COLLECT);
  assign in_hs_c     = i_Valid && o_Ready;
  assign out_hs_c    = o_Valid && i_Ready;
  assign o_Core_Data = core_data_q;
  assign o_Word      = word_q;
  assign o_Err       = err_q;

  // State and datapath registers
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q     <= S_COLLECT;
      cnt_q       <= '0;
      ocnt_q      <= '0;
      key_q       <= '0;
      text_q      <= '0;
      result_q    <= '0;
      mode_q      <= 1'b0;
      wdog_q      <= '0;
      core_data_q <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ocnt_q      <= ocnt_d;
      key_q       <= key_d;
      text_q      <= text_d;
      result_q    <= result_d;
      mode_q      <= mode_d;
      wdog_q      <= wdog_d;
      core_data_q <= core_data_d;
      word_q      <= word_d;
      err_q       <= err_d;
    end
  end

  // Next-state, datapath updates and registered-output precompute
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ocnt_d      = ocnt_q;
    key_d       = key_q;
    text_d      = text_q;
    result_d    = result_q;
    mode_d      = mode_q;
    wdog_d      = wdog_q;
    err_d       = 1'b0;
    core_data_d = '0;
    word_d      = '0;

    case (state_q)
      S_COLLECT: begin
        if (in_hs_c) begin
          // Words arrive MS first, so shifting in fills each block in order
          if (cnt_q < 3'd4) begin
            key_d = {key_q[BLK_W-WORD_W-1:0], i_Word};
          end else begin
            text_d = {text_q[BLK_W-WORD_W-1:0], i_Word};
          end
          if (cnt_q == 3'd0) begin
            mode_d = i_Mode;
          end
          if (cnt_q == 3'd7) begin
            cnt_d   = '0;
            state_d = S_LOAD_TEXT;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_LOAD_TEXT: state_d = S_LOAD_KEY;
      S_LOAD_KEY:  state_d = S_WAIT;
      S_WAIT: begin
        if (i_Core_Done) begin
          result_d = i_Core_Text;
          wdog_d   = '0;
          state_d  = S_OUT;
        end else if (wdog_q == WDW'(TIMEOUT)) begin
          // Core hung: flag it and drop everything collected so far
          err_d   = 1'b1;
          wdog_d  = '0;
          key_d   = '0;
          text_d  = '0;
          mode_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_COLLECT;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      S_OUT: begin
        if (out_hs_c) begin
          if (ocnt_q == 2'd3) begin
            ocnt_d  = '0;
            state_d = S_COLLECT;
          end else begin
            ocnt_d = ocnt_q + 2'd1;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase

    // Core bus follows the state being entered so it is valid for that whole cycle
    case (state_d)
      S_LOAD_TEXT: core_data_d = {1'b1, text_d};
      S_LOAD_KEY:  core_data_d = {mode_d, key_d};
      default:     core_data_d = '0;
    endcase

    // Output word for the state being entered, MS word first
    if (state_d == S_OUT) begin
      case (ocnt_d)
        2'd0:    word_d = result_d[127:96];
        2'd1:    word_d = result_d[95:64];
        2'd2:    word_d = result_d[63:32];
        default: word_d = result_d[31:0];
      endcase
    end
  end

endmodule

// File: tb/tb_seed_word_loader.sv
// Testbench for seed_word_loader with a behavioural SEED core stand-in.
module tb_seed_word_loader;

  localparam logic [127:0] PT = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] CT = 128'h5EBAC6E0_054E1668_19AFF1CC_6D346CDB;
  localparam logic [127:0] K0 = 128'h0;
  localparam int unsigned  TO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid, o_ready, i_mode, o_valid, i_ready, o_busy, o_err;
  logic [31:0]  i_word, o_word;
  logic [128:0] core_data;
  logic [127:0] core_text;
  logic         stub_done, spur, core_done;
  bit           hang, spur_en;
  int           n_chk = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  seed_word_loader #(.TIMEOUT(TO)) dut (
    .i_Clk(clk), .i_Rst(rst_n),
    .i_Valid(i_valid), .o_Ready(o_ready), .i_Word(i_word), .i_Mode(i_mode),
    .o_Core_Data(core_data), .i_Core_Text(core_text), .i_Core_Done(core_done),
    .o_Valid(o_valid), .i_Ready(i_ready), .o_Word(o_word),
    .o_Busy(o_busy), .o_Err(o_err)
  );

  // Core model: known SEED answers for the test vectors, a reversible mix otherwise
  function automatic logic [127:0] ref_core(input logic [127:0] key, input logic [127:0] text,
                                            input logic mode);
    if (!mode && key == K0 && text == PT) return CT;
    if (mode && key == K0 && text == CT) return PT;
    return text ^ key ^ (mode ? 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0
                              : 128'hA5A5A5A5_5A5A5A5A_3C3C3C3C_C3C3C3C3);
  endfunction

  // Core stub: latch text then key/mode from the bus, answer after a fixed latency
  logic [1:0]   st_phase;
  logic [127:0] st_txt, st_key;
  logic         st_mode;
  int           st_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_phase <= 2'd0; st_txt <= '0; st_key <= '0; st_mode <= 1'b0; st_cnt <= 0;
      stub_done <= 1'b0; core_text <= '0;
    end else begin
      stub_done <= 1'b0;
      core_text <= {$urandom(), $urandom(), $urandom(), $urandom()};
      case (st_phase)
        2'd0: if (core_data[128]) begin st_txt <= core_data[127:0]; st_phase <= 2'd1; end
        2'd1: begin
          st_key <= core_data[127:0]; st_mode <= core_data[128]; st_cnt <= 0; st_phase <= 2'd2;
        end
        default: begin
          if (st_cnt == (st_mode ? 9 : 5)) begin
            st_phase <= 2'd0;
            if (!hang) begin
              stub_done <= 1'b1;
              core_text <= ref_core(st_key, st_txt, st_mode);
            end
          end else begin
            st_cnt <= st_cnt + 1;
          end
        end
      endcase
    end
  end
  assign core_done = stub_done | spur;

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Push key then text words, optionally with random idle gaps
  task automatic send_words(input logic [127:0] key, input logic [127:0] text,
                            input logic mode, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      int n;
      if (gaps) begin
        int g;
        i_valid = 1'b0;
        g = $urandom_range(0, 3);
        repeat (g) step();
      end
      i_word  = (i < 4) ? key[127-32*i -: 32] : text[127-32*(i-4) -: 32];
      i_mode  = (i == 0) ? mode : 1'($urandom());
      i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 50) begin step(); n++; end
      if (n == 50) check("ready_timeout", 129'(o_ready), 129'(1));
      step();
      spur = spur_en && (i == 2);
    end
    i_valid = 1'b0;
    spur    = 1'b0;
  endtask

  // Full transaction with load-sequence, back-pressure and result checks
  task automatic do_txn(input string tag, input logic [127:0] key, input logic [127:0] text,
                        input logic mode, input bit gaps, input bit bp, input logic [127:0] exp);
    int  n;
    bit  bad;
    send_words(key, text, mode, gaps);
    check({tag, " load_text"}, core_data, {1'b1, text});
    check({tag, " ready_low"}, 129'(o_ready), 129'(0));
    step();
    check({tag, " load_key"}, core_data, {mode, key});
    step();
    check({tag, " bus_idle"}, core_data, 129'(0));
    n = 0; bad = 1'b0;
    while (!o_valid && n < 200) begin
      if (o_ready !== 1'b0 || core_data !== '0 || o_busy !== 1'b1) bad = 1'b1;
      step(); n++;
    end
    check({tag, " valid_seen"}, 129'(n < 200), 129'(1));
    check({tag, " wait_quiet"}, 129'(bad), 129'(0));
    if (n >= 200) return;
    i_ready = !bp;
    for (int w = 0; w < 4; w++) begin
      logic [31:0] ew;
      ew  = exp[127-32*w -: 32];
      bad = 1'b0;
      if (bp) begin
        i_ready = 1'b0;
        repeat (5) begin
          if (o_valid !== 1'b1 || o_word !== ew || o_ready !== 1'b0) bad = 1'b1;
          step();
        end
        i_ready = 1'b1;
      end
      if (o_valid !== 1'b1 || o_ready !== 1'b0) bad = 1'b1;
      check($sformatf("%s word%0d", tag, w), 129'(o_word), 129'(ew));
      check($sformatf("%s hold%0d", tag, w), 129'(bad), 129'(0));
      step();
    end
    i_ready = 1'b0;
    check({tag, " valid_done"}, 129'(o_valid), 129'(0));
    check({tag, " ready_back"}, 129'(o_ready), 129'(1));
    check({tag, " busy_done"}, 129'(o_busy), 129'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"}, 129'(o_ready), 129'(1));
    check({tag, " valid"}, 129'(o_valid), 129'(0));
    check({tag, " word"}, 129'(o_word), 129'(0));
    check({tag, " core"}, core_data, 129'(0));
    check({tag, " busy"}, 129'(o_busy), 129'(0));
    check({tag, " err"}, 129'(o_err), 129'(0));
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] text;
    logic         mode;
    bit           gaps;
    bit           bp;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int t;
    rst_n = 1'b0; i_valid = 1'b0; i_word = '0; i_mode = 1'b0; i_ready = 1'b0;
    hang = 1'b0; spur = 1'b0; spur_en = 1'b0;

    tbl[0] = '{K0, PT, 1'b0, 1'b0, 1'b0, CT};
    tbl[1] = '{K0, CT, 1'b1, 1'b0, 1'b0, PT};
    tbl[2] = '{K0, PT, 1'b0, 1'b1, 1'b1, CT};
    tbl[3] = '{128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
               1'b0, 1'b1, 1'b0, 128'h0};
    tbl[4] = '{128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 128'h0, 1'b1, 1'b0, 1'b1, 128'h0};
    tbl[3].exp = ref_core(tbl[3].key, tbl[3].text, tbl[3].mode);
    tbl[4].exp = ref_core(tbl[4].key, tbl[4].text, tbl[4].mode);

    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    check_reset_outputs("post_reset");

    foreach (tbl[i])
      do_txn($sformatf("vec%0d", i), tbl[i].key, tbl[i].text, tbl[i].mode,
             tbl[i].gaps, tbl[i].bp, tbl[i].exp);

    // Randomized transactions with spurious core done during collection
    spur_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      logic [127:0] k, x;
      logic         m;
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      m = 1'($urandom());
      do_txn($sformatf("rnd%0d", r), k, x, m, 1'($urandom()), 1'($urandom()), ref_core(k, x, m));
    end
    spur_en = 1'b0;

    // Watchdog: core never finishes
    hang = 1'b1;
    send_words(K0, PT, 1'b0, 1'b0);
    step();
    step();
    check("wd wait_entry_busy", 129'(o_busy), 129'(1));
    t = 0;
    while (!o_err && t < 40) begin step(); t++; end
    check("wd err_cycle", 129'(t), 129'(TO + 1));
    check("wd ready_at_err", 129'(o_ready), 129'(1));
    step();
    check("wd err_pulse", 129'(o_err), 129'(0));
    check("wd ready_next", 129'(o_ready), 129'(1));
    hang = 1'b0;
    do_txn("after_wd", K0, PT, 1'b0, 1'b0, 1'b0, CT);

    // Reset while waiting on the core
    hang = 1'b1;
    send_words(K0, CT, 1'b1, 1'b0);
    repeat (6) step();
    check("rst busy_before", 129'(o_busy), 129'(1));
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    step();
    rst_n = 1'b1;
    hang  = 1'b0;
    step();
    check("rst ready_after", 129'(o_ready), 129'(1));
    do_txn("after_rst", K0, PT, 1'b0, 1'b1, 1'b0, CT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seed_word_loader.md
Name: seed_word_loader

Overview:
- Front-end sequencer for the SEED core.
- Collects a 128-bit key and a 128-bit text block as 32-bit words over a valid/ready stream.
- Presents them to the core's 129-bit i_Data port in the core's required two-cycle load order, then waits for core completion.
- Captures the 128-bit result and returns it as four 32-bit words over a second valid/ready stream, with a watchdog against a hung core.

Parameters:
- TIMEOUT, 255, max cycles spent in S_WAIT before abort; counter width = clog2(TIMEOUT+1).

Ports:
- i_Clk  input  1  clock
- i_Rst  input  1  reset, asynchronous, active-low
- i_Valid  input  1  input word valid
- o_Ready  output  1  loader accepts input word
- i_Word  input  32  input word: key words 0-3, then text words 4-7, MS word first
- i_Mode  input  1  0=encrypt, 1=decrypt; sampled only with word 0
- o_Core_Data  output  129  to SEED core i_Data
- i_Core_Text  input  128  from SEED core o_Text
- i_Core_Done  input  1  from SEED core o_fDone
- o_Valid  output  1  output word valid
- i_Ready  input  1  downstream accepts output word
- o_Word  output  32  result word, MS word first
- o_Busy  output  1  high in any state except S_COLLECT
- o_Err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: state=S_COLLECT, word count=0, key/text/result/mode regs=0, watchdog=0. Outputs: o_Ready=1 (state-decoded), o_Valid=0, o_Word=0, o_Core_Data=0, o_Busy=0, o_Err=0.
- Registers: o_Core_Data, o_Word, o_Err. o_Ready, o_Valid and o_Busy are decoded from state.
- Handshakes: a transfer occurs on a cycle where valid and ready are both high. o_Valid/o_Word must be held stable until accepted.
- S_COLLECT:
  - o_Ready=1.
  - On each input handshake, store i_Word at slot cnt and increment cnt (3 bits). Slots 0-3 form key[127:0], slots 4-7 form text[127:0].
  - Latch i_Mode when cnt=0.
  - On the handshake with cnt=7: go to S_LOAD_TEXT and clear cnt.
  - o_Core_Data=0 throughout, so core bit 128 stays 0 while the core is idle.
- S_LOAD_TEXT (1 cycle):
  - o_Core_Data={1'b1, text}; the core latches L/R and leaves its idle state.
  - Then go to S_LOAD_KEY.
- S_LOAD_KEY (1 cycle):
  - o_Core_Data={mode, key}; the core latches key and direction.
  - Then go to S_WAIT.
- S_WAIT:
  - o_Core_Data=0; watchdog increments each cycle.
  - On i_Core_Done=1: result<=i_Core_Text (valid only that cycle), clear watchdog, go to S_OUT.
  - Else if watchdog==TIMEOUT: pulse o_Err, clear watchdog, discard buffers, go to S_COLLECT.
  - Nominal core latency: 81 cycles encrypt, 113 cycles decrypt, so TIMEOUT must be ≥120 in use.
- S_OUT:
  - o_Valid=1, o_Word=result word ocnt (ocnt=0 gives [127:96]).
  - On each handshake, increment ocnt. After the handshake with ocnt=3: clear ocnt and go to S_COLLECT; o_Ready rises the next cycle.
  - o_Ready=0 here; input is back-pressured and there is no overlap.
- i_Core_Done outside S_WAIT is ignored.
- i_Valid while o_Ready=0 is ignored. The source must hold the word; nothing is dropped.
- Reset mid-operation: all state is discarded immediately. The core shares i_Rst and restarts in step.
- The loader never drives bit 128 high except in S_LOAD_TEXT, and in S_LOAD_KEY when mode=1.

Test Plan:
- Encrypt known answer: key=0x0000..00, text=0x00010203_04050607_08090A0B_0C0D0E0F, mode=0 -> output words 5EBAC6E0, 054E1668, 19AFF1CC, 6D346CDB.
- Decrypt round trip: key=0, text=5EBAC6E0_054E1668_19AFF1CC_6D346CDB, mode=1 -> output 00010203, 04050607, 08090A0B, 0C0D0E0F. Check o_Core_Data[128]=1 in both load cycles.
- Load timing against a core stub: after the 8th input handshake, check o_Core_Data={1,text} for exactly one cycle, then {mode,key} for exactly one cycle, then 0; check o_Ready=0 until the output phase completes.
- Back-pressure: hold i_Ready=0 for 5 cycles on each output word -> o_Word stable, no word lost or duplicated. Gaps in i_Valid during collect (random 0-3 cycles) -> same result.
- Watchdog with TIMEOUT=16 and a stub that never asserts done -> o_Err pulses 1 cycle, 17 cycles after S_WAIT entry; o_Ready=1 the next cycle; a following full transaction succeeds.
- Assert i_Rst low during S_WAIT -> all outputs return to reset values; o_Ready=1 after release; a fresh encrypt returns the correct ciphertext.
